npu_spi_slave: RTL and testbench

- SPI target (slave) front end of the NPU. Oversamples the external master's spi_ss/spi_sclk/spi_mosi on the system clock.
- Receive path: assembles LSB-first bytes into 16-bit words, low byte first, and presents them to the NPU command/load logic.
- Transmit path: serialises NPU result words onto spi_miso with the same bit and byte order.
- Supports the master's timing of 4 clk per sclk period (2 high, 2 low), with spi_ss deasserted between bytes.

---
 rtl/npu_spi_slave_if.sv | 26 ++
 rtl/npu_spi_slave.sv | 204 ++++++++++++++++++++
 tb/tb_npu_spi_slave.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/npu_spi_slave_if.sv
// SPI pins plus NPU-side receive/transmit handshake for the NPU SPI target.
interface npu_spi_slave_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  spi_ss;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  frame_err;
  logic                  tx_underflow;

  modport slave (
    input  spi_ss, spi_sclk, spi_mosi, tx_data, tx_valid,
    output spi_miso, rx_data, rx_valid, tx_ready, frame_err, tx_underflow
  );

  modport master (
    output spi_ss, spi_sclk, spi_mosi, tx_data, tx_valid,
    input  spi_miso, rx_data, rx_valid, tx_ready, frame_err, tx_underflow
  );
endinterface

// File: rtl/npu_spi_slave.sv
// SPI mode-0 target: oversampled pins, LSB-first bytes assembled low-byte-first
// into words on receive, and the same order serialised onto miso on transmit.
module npu_spi_slave #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic           soft_reset,
  npu_spi_slave_if.slave bus
);
  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int unsigned PHASE_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned TX_CNT_W = $clog2(DATA_WIDTH);
  localparam logic [PHASE_W-1:0]  PH_LAST = PHASE_W'(BYTES_PER_WORD - 1);
  localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [1:0] ss_sync, sclk_sync, mosi_sync;
  logic       ss_prev, sclk_prev;
  logic       ss_s, mosi_s;
  logic       sclk_rise_c, ss_fall_c, ss_rise_c, bit_rise_c;

  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d, cnt_base;
  logic [7:0]            rx_byte_q, rx_byte_d, byte_shift_c;
  logic [DATA_WIDTH-1:0] rx_acc_q, rx_acc_d, rx_word_c;
  logic [DATA_WIDTH+7:0] rx_cat_c;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_pend_q, rx_pend_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [TX_CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  miso_q, miso_d;
  logic                  underflow_q, underflow_d;

  // Pin synchronisers plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else if (soft_reset) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[0], bus.spi_ss};
      sclk_sync <= {sclk_sync[0], bus.spi_sclk};
      mosi_sync <= {mosi_sync[0], bus.spi_mosi};
      ss_prev   <= ss_sync[1];
      sclk_prev <= sclk_sync[1];
    end
  end

  assign ss_s        = ss_sync[1];
  assign mosi_s      = mosi_sync[1];
  assign sclk_rise_c = sclk_sync[1] & ~sclk_prev;
  assign ss_fall_c   = ~ss_s & ss_prev;
  assign ss_rise_c   = ss_s & ~ss_prev;
  // A rise coinciding with the ss rise still belongs to the closing byte
  assign bit_rise_c  = sclk_rise_c & ~(ss_s & ss_prev);

  assign cnt_base     = ss_fall_c ? 4'd0 : bit_cnt_q;
  assign byte_shift_c = {mosi_s, rx_byte_q[7:1]};
  assign rx_cat_c     = {byte_shift_c, rx_acc_q};
  assign rx_word_c    = rx_cat_c[DATA_WIDTH+7:8];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_byte_q   <= '0;
      rx_acc_q    <= '0;
      phase_q     <= '0;
      rx_data_q   <= '0;
      rx_pend_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_shift_q  <= '0;
      tx_cnt_q    <= '0;
      tx_ready_q  <= 1'b1;
      miso_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_acc_q    <= rx_acc_d;
      phase_q     <= phase_d;
      rx_data_q   <= rx_data_d;
      rx_pend_q   <= rx_pend_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_ready_q  <= tx_ready_d;
      miso_q      <= miso_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_byte_d   = rx_byte_q;
    rx_acc_d    = rx_acc_q;
    phase_d     = phase_q;
    rx_data_d   = rx_data_q;
    rx_pend_d   = 1'b0;
    rx_valid_d  = rx_pend_q;
    frame_err_d = 1'b0;
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    tx_ready_d  = tx_ready_q;
    miso_d      = miso_q;
    underflow_d = 1'b0;

    if (soft_reset) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      rx_byte_d  = '0;
      rx_acc_d   = '0;
      phase_d    = '0;
      rx_data_d  = '0;
      rx_valid_d = 1'b0;
      tx_shift_d = '0;
      tx_cnt_d   = '0;
      tx_ready_d = 1'b1;
      miso_d     = 1'b0;
    end else begin
      if (ss_fall_c) begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
      end

      // Receive: shift mosi in, close the byte on its 8th bit
      if (bit_rise_c) begin
        rx_byte_d = byte_shift_c;
        if (cnt_base == 4'd7) begin
          bit_cnt_d = 4'd8;
          if (phase_q == PH_LAST) begin
            rx_data_d = rx_word_c;
            rx_pend_d = 1'b1;
            phase_d   = '0;
          end else begin
            rx_acc_d = rx_word_c;
            phase_d  = phase_q + PHASE_W'(1);
          end
        end else if (cnt_base == 4'd8) begin
          bit_cnt_d = 4'd1;
        end else begin
          bit_cnt_d = cnt_base + 4'd1;
        end
      end

      if (ss_rise_c) begin
        state_d = IDLE;
        if (state_q == SHIFT && bit_cnt_d != 4'd0 && bit_cnt_d != 4'd8) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          rx_byte_d   = '0;
          phase_d     = '0;
        end
      end

      // Transmit: each master rise consumes the bit on miso and exposes the next
      if (bit_rise_c) begin
        if (tx_ready_q) begin
          underflow_d = 1'b1;
          miso_d      = 1'b0;
        end else if (tx_cnt_q == TX_LAST) begin
          tx_ready_d = 1'b1;
          tx_cnt_d   = '0;
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          miso_d     = tx_shift_q[1];
          tx_cnt_d   = tx_cnt_q + TX_CNT_W'(1);
        end
      end

      if (tx_ready_q && bus.tx_valid) begin
        tx_shift_d = bus.tx_data;
        tx_cnt_d   = '0;
        tx_ready_d = 1'b0;
        miso_d     = bus.tx_data[0];
      end
    end
  end

  assign bus.spi_miso     = miso_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.tx_ready     = tx_ready_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.tx_underflow = underflow_q;
endmodule

// File: tb/tb_npu_spi_slave.sv
// Bench for npu_spi_slave: an SPI master model drives byte frames, a scoreboard
// checks received words, and read captures are compared with the loaded words.
module tb_npu_spi_slave;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset_b;
  logic soft_reset;

  npu_spi_slave_if #(.DATA_WIDTH(DW)) bus ();

  npu_spi_slave #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int uf_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid pops one expected word
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected got=%0h exp=none", bus.rx_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("rx_word", 32'(bus.rx_data), 32'(e));
      end
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.tx_underflow === 1'b1) uf_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master byte frame: 2 clk low, 2 clk high per bit; miso sampled at the rise
  task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit keep_ss,
                          output logic [7:0] mi, output bit stable, output logic [7:0] rdy);
    logic m_pre;
    mi = '0;
    rdy = '0;
    stable = 1'b1;
    bus.spi_ss = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = mo[i];
      bus.spi_sclk = 1'b0;
      wait_clk(1);
      m_pre = bus.spi_miso;
      wait_clk(1);
      if (bus.spi_miso !== m_pre) stable = 1'b0;
      mi[i]  = bus.spi_miso;
      rdy[i] = bus.tx_ready;
      bus.spi_sclk = 1'b1;
      wait_clk(2);
    end
    bus.spi_sclk = 1'b0;
    wait_clk(2);
    if (!keep_ss) begin
      bus.spi_ss = 1'b1;
      wait_clk(4);
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w, output logic [DW-1:0] cap,
                           output bit stable, output logic [DW-1:0] rdy);
    logic [7:0] lo, hi, rlo, rhi;
    bit s0, s1;
    spi_byte(w[7:0], 8, 1'b0, lo, s0, rlo);
    spi_byte(w[15:8], 8, 1'b0, hi, s1, rhi);
    cap = {hi, lo};
    rdy = {rhi, rlo};
    stable = s0 & s1;
  endtask

  task automatic load_tx(input logic [DW-1:0] w);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, 32'(bus.spi_miso), 32'd0);
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_underflow"}, 32'(bus.tx_underflow), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] cap, rdy;
    logic [7:0] b, rb;
    bit st;
    int uf_base;
    logic [DW-1:0] words[3];
    words[0] = 16'h0008;
    words[1] = 16'h0003;
    words[2] = 16'h000A;

    reset_b      = 1'b0;
    soft_reset   = 1'b0;
    bus.spi_ss   = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    wait_clk(3);
    check_reset_outputs("por");
    reset_b = 1'b1;
    wait_clk(5);

    // Single word, low byte first
    exp_q.push_back(16'h0310);
    send_word(16'h0310, cap, st, rdy);
    wait_clk(4);
    check("ferr_after_0310", 32'(ferr_cnt), 32'd0);

    // Back-to-back words
    foreach (words[i]) begin
      exp_q.push_back(words[i]);
      send_word(words[i], cap, st, rdy);
    end
    wait_clk(4);
    check("queue_after_b2b", 32'(exp_q.size()), 32'd0);

    // Read of a preloaded word; mosi zeros are still received as a word
    load_tx(16'hA5C3);
    check("tx_ready_after_load", 32'(bus.tx_ready), 32'd0);
    check("miso_bit0_after_load", 32'(bus.spi_miso), 32'd1);
    uf_base = uf_cnt;
    exp_q.push_back(16'h0000);
    send_word(16'h0000, cap, st, rdy);
    check("tx_capture_a5c3", 32'(cap), 32'hA5C3);
    check("tx_miso_stable", 32'(st), 32'd1);
    check("tx_ready_low_all_rises", 32'(rdy), 32'd0);
    check("tx_ready_after_word", 32'(bus.tx_ready), 32'd1);
    check("tx_no_underflow", 32'(uf_cnt - uf_base), 32'd0);

    // Aborted byte after 4 bits, then a clean word
    spi_byte(8'hFF, 4, 1'b0, b, st, rb);
    wait_clk(2);
    check("ferr_after_abort", 32'(ferr_cnt), 32'd1);
    exp_q.push_back(16'h1234);
    send_word(16'h1234, cap, st, rdy);
    wait_clk(4);
    check("queue_after_1234", 32'(exp_q.size()), 32'd0);

    // Read with nothing loaded
    uf_base = uf_cnt;
    exp_q.push_back(16'h0000);
    send_word(16'h0000, cap, st, rdy);
    wait_clk(2);
    check("underflow_pulses", 32'(uf_cnt - uf_base), 32'd16);
    check("underflow_capture", 32'(cap), 32'd0);

    // Hard reset in the middle of the high byte with a tx word loaded
    load_tx(16'h5A5A);
    check("tx_ready_before_rst", 32'(bus.tx_ready), 32'd0);
    spi_byte(8'hAD, 8, 1'b0, b, st, rb);
    spi_byte(8'hDE, 5, 1'b1, b, st, rb);
    reset_b = 1'b0;
    wait_clk(2);
    check_reset_outputs("mid_rst");
    bus.spi_ss = 1'b1;
    wait_clk(3);
    check_reset_outputs("held_rst");
    reset_b = 1'b1;
    wait_clk(5);
    exp_q.push_back(16'hBEEF);
    send_word(16'hBEEF, cap, st, rdy);
    wait_clk(4);
    check("queue_after_beef", 32'(exp_q.size()), 32'd0);

    // Soft reset between bytes clears byte phase and a partly sent tx word
    load_tx(16'hFFFF);
    spi_byte(8'h77, 8, 1'b0, b, st, rb);
    check("miso_mid_word", 32'(bus.spi_miso), 32'd1);
    soft_reset = 1'b1;
    wait_clk(1);
    soft_reset = 1'b0;
    check("soft_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("soft_rst_miso", 32'(bus.spi_miso), 32'd0);
    wait_clk(4);
    exp_q.push_back(16'h4321);
    send_word(16'h4321, cap, st, rdy);
    wait_clk(8);

    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    check("frame_err_total", 32'(ferr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
